mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 14, line address width; LINE_W, default 64, line data width; TIMEOUT_CYC, default 255, maximum busy cycles without m_rdy.
REQ-002 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_req  input  1  I-cache fill request; held until i_done.
REQ-005 i_addr  input  ADDR_W  I-cache fill line address.
REQ-006 i_done  output  1  one-cycle completion pulse to the I-cache.
REQ-007 i_rdata  output  LINE_W  fill line, valid only while i_done=1.
REQ-008 d_req  input  1  D-cache request; held until d_done.
REQ-009 d_we  input  1  1 = write-back, 0 = fill.
REQ-010 d_lock  input  1  keep the grant for the following D transaction (write-back then fill).
REQ-011 d_addr  input  ADDR_W  D-cache line address.
REQ-012 d_wdata  input  LINE_W  write-back line.
REQ-013 d_done  output  1  one-cycle completion pulse to the D-cache.
REQ-014 d_rdata  output  LINE_W  fill line, valid only while d_done=1.
REQ-015 m_re, m_we  output  1 each  registered memory read/write strobes; never both 1.
REQ-016 m_addr  output  ADDR_W  registered memory line address.
REQ-017 m_wdata  output  LINE_W  registered memory write line.
REQ-018 m_rdy  input  1  memory completes the current access in this cycle.
REQ-019 m_rdata  input  LINE_W  memory read line, valid with m_rdy.
REQ-020 busy  output  1  1 when state is not IDLE.
REQ-021 timeout_err  output  1  sticky watchdog flag.

Function
REQ-022 States SHALL be IDLE, GNT_I, and GNT_D.
REQ-023 In IDLE with exactly one request high, the arbiter SHALL grant that requester at the next edge.
REQ-024 In IDLE with both requests high, the arbiter SHALL grant the requester not in last_gnt, then update last_gnt; last_gnt SHALL reset to I, so D wins the first tie.
REQ-025 At the grant edge the arbiter SHALL latch addr, we and wdata into m_addr, m_we/m_re and m_wdata; a request seen in IDLE at cycle N SHALL have strobes high in cycle N+1.
REQ-026 In GNT_x the strobes and address SHALL hold steady until the m_rdy cycle; requester inputs SHALL be ignored after latching.
REQ-027 In the m_rdy cycle the arbiter SHALL assert x_done combinationally and drive x_rdata = m_rdata; on a write-back, rdata SHALL be 0.
REQ-028 At the edge after m_rdy the arbiter SHALL clear the strobes and return to IDLE.
REQ-029 Exception to REQ-028: if the grant is D, the D transaction had d_lock=1, and d_req=1 at that edge, the arbiter SHALL stay in GNT_D and latch the new D request (zero-bubble back-to-back), even if i_req is pending.
REQ-030 Each requester SHALL drop req at the edge where done is sampled, unless it is issuing a new request; a req high in IDLE is always a new request.
REQ-031 A watchdog counter, 8 bits, SHALL clear on every grant and increment each GNT cycle without m_rdy.
REQ-032 When the counter reaches TIMEOUT_CYC, the arbiter SHALL set timeout_err, pulse x_done with rdata 0, and return to IDLE; timeout_err SHALL clear only on reset.
REQ-033 i_done and d_done SHALL never be high in the same cycle.
REQ-034 m_rdy in IDLE SHALL be ignored.
REQ-035 busy SHALL equal (state != IDLE).

Reset
REQ-036 Asserting rst_n low SHALL asynchronously force: state IDLE; m_re, m_we, m_addr, m_wdata all 0; last_gnt I; watchdog 0; timeout_err 0; done outputs 0.
REQ-037 Reset mid-transaction SHALL drop the transaction with no done pulse; requesters reissue after reset.

Structure
REQ-038 Package mem_pkg SHALL hold the state enum, the ADDR_W/LINE_W/TIMEOUT_CYC defaults, and grant-ID constants (GNT_ID_I, GNT_ID_D).
REQ-039 The 2-way round-robin picker SHALL be sub-module arb_rr2 (inputs: req[1:0], last; output: winner).
REQ-040 The FSM, latches and watchdog SHALL remain in mem_arbiter.

Verification
REQ-041 Case: i_req with i_addr=0x0010, memory m_rdy 3 cycles after m_re. Required: m_re high next cycle, m_addr=0x0010; i_done pulses 1 cycle with i_rdata=m_rdata; then back to IDLE.
REQ-042 Case: i_req and d_req rise together after reset. Required: D granted first; I granted the cycle after d_done+1; repeat the tie and I wins (alternation).
REQ-043 Case: d_we=1, d_lock=1, addr 0x1A05, then fill of 0x0305 with i_req pending. Required: m_we then m_re with no IDLE cycle between; I served after the fill.
REQ-044 Case: grant D, m_rdy held 0 for 255 cycles. Required: timeout_err=1, d_done pulse with d_rdata=0, state IDLE; flag persists until reset.
REQ-045 Case: rst_n low during GNT_I while m_re=1. Required: m_re=0 immediately (asynchronously), no i_done, state IDLE after release.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and defaults for the I/D-cache to memory arbiter.
package mem_pkg;

  localparam int DEF_ADDR_W      = 14;
  localparam int DEF_LINE_W      = 64;
  localparam int DEF_TIMEOUT_CYC = 255;

  // Width of the busy-cycle watchdog counter.
  localparam int WD_W = 8;

  localparam logic GNT_ID_I = 1'b0;
  localparam logic GNT_ID_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker: req[0] is the I-cache, req[1] the D-cache.
module arb_rr2
  import mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner
);

  always_comb begin
    case (req)
      2'b01:   winner = GNT_ID_I;
      2'b10:   winner = GNT_ID_D;
      // On a tie the side that did not win the previous tie goes first.
      2'b11:   winner = ~last;
      default: winner = last;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port line memory shared by I-cache fills and D-cache fills/write-backs,
// with round-robin tie breaking, locked D back-to-back and a busy watchdog.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int LINE_W      = DEF_LINE_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [LINE_W-1:0] i_rdata,

  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_lock,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_done,
  output logic [LINE_W-1:0] d_rdata,

  output logic              m_re,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [LINE_W-1:0] m_wdata,
  input  logic              m_rdy,
  input  logic [LINE_W-1:0] m_rdata,

  output logic              busy,
  output logic              timeout_err
);

  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYC);

  state_t          state_q;
  state_t          state_d;
  logic            last_gnt_q;
  logic            lock_q;
  logic [WD_W-1:0] wd_q;
  logic            timeout_err_q;

  logic            winner;
  logic            tie;
  logic            in_gnt;
  logic            tmo;
  logic            fin;
  logic            start_i;
  logic            start_d;

  arb_rr2 u_arb (
    .req    ({d_req, i_req}),
    .last   (last_gnt_q),
    .winner (winner)
  );

  assign tie    = i_req & d_req;
  assign in_gnt = (state_q != IDLE);
  // A real m_rdy in the limit cycle still completes normally.
  assign tmo    = in_gnt & ~m_rdy & (wd_q == WD_LIMIT);
  assign fin    = in_gnt & (m_rdy | tmo);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    start_i = 1'b0;
    start_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          if (winner == GNT_ID_D) begin
            state_d = GNT_D;
            start_d = 1'b1;
          end else begin
            state_d = GNT_I;
            start_i = 1'b1;
          end
        end
      end
      GNT_I: begin
        if (fin) begin
          state_d = IDLE;
        end
      end
      GNT_D: begin
        // A locked D transaction hands straight over to the next D request.
        if (m_rdy && lock_q && d_req) begin
          start_d = 1'b1;
        end else if (fin) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    i_done  = 1'b0;
    d_done  = 1'b0;
    i_rdata = '0;
    d_rdata = '0;
    case (state_q)
      GNT_I: begin
        i_done = fin;
        if (m_rdy) begin
          i_rdata = m_rdata;
        end
      end
      GNT_D: begin
        d_done = fin;
        if (m_rdy && !m_we) begin
          d_rdata = m_rdata;
        end
      end
      default: ;
    endcase
  end

  assign busy        = in_gnt;
  assign timeout_err = timeout_err_q;

  // Memory-side request registers, loaded only at a grant edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_re    <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      lock_q  <= 1'b0;
    end else if (start_i) begin
      m_re    <= 1'b1;
      m_we    <= 1'b0;
      m_addr  <= i_addr;
      m_wdata <= '0;
      lock_q  <= 1'b0;
    end else if (start_d) begin
      m_re    <= ~d_we;
      m_we    <= d_we;
      m_addr  <= d_addr;
      m_wdata <= d_wdata;
      lock_q  <= d_lock;
    end else if (fin) begin
      m_re    <= 1'b0;
      m_we    <= 1'b0;
      lock_q  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q          <= '0;
      last_gnt_q    <= GNT_ID_I;
      timeout_err_q <= 1'b0;
    end else begin
      if (start_i || start_d) begin
        wd_q <= '0;
      end else if (in_gnt && !m_rdy) begin
        wd_q <= wd_q + 1'b1;
      end
      // Only contested grants move the round-robin pointer.
      if (state_q == IDLE && tie) begin
        last_gnt_q <= winner;
      end
      if (tmo) begin
        timeout_err_q <= 1'b1;
      end
    end
  end

endmodule
